// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

    localparam int INST_WIDTH      = 32;
    localparam int INST_ADDR_WIDTH = 32;

    // addi x0, x0, 0: what decode sees while nothing valid is presented
    localparam logic [INST_WIDTH-1:0]      INST_NOP           = 32'h0000_0013;
    localparam logic [INST_ADDR_WIDTH-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    // IF_DONE is the non-requesting wait after a response landed in the skid
    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2,
        IF_DONE = 2'd3
    } if_state_e;

    // Fetches are always word aligned; low address bits are simply dropped.
    function automatic logic [INST_ADDR_WIDTH-1:0] word_align(
        input logic [INST_ADDR_WIDTH-1:0] addr
    );
        return {addr[INST_ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_skid.sv
// One-entry holding buffer for a fetched word that arrives while decode is stalled.
module inst_fetch_skid
    import inst_fetch_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       load_i,
    input  logic                       drain_i,
    input  logic [INST_WIDTH-1:0]      inst_i,
    input  logic [INST_ADDR_WIDTH-1:0] addr_i,
    output logic                       valid_o,
    output logic [INST_WIDTH-1:0]      inst_o,
    output logic [INST_ADDR_WIDTH-1:0] addr_o
);

    logic                       valid_q, valid_d;
    logic [INST_WIDTH-1:0]      inst_q, inst_d;
    logic [INST_ADDR_WIDTH-1:0] addr_q, addr_d;

    // Clear (redirect) beats load, load beats drain.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            addr_d  = addr_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= INST_NOP;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, single-outstanding imem handshake, fetch/decode register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IF_IDLE | first cycle after reset release, no request
// IF_REQ  | request asserted at PC, waiting for grant
// IF_WAIT | granted, waiting for the response (dropped if drop_q set)
// IF_DONE | response parked in skid; no request until skid drains
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       jump_en_i,
    input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                       hold_i,
    output logic                       imem_req_o,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [INST_WIDTH-1:0]      imem_rdata_i,
    output logic [INST_WIDTH-1:0]      inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic                       inst_valid_o
);

    if_state_e                  state_q, state_d;
    logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INST_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                       drop_q, drop_d;
    logic [INST_WIDTH-1:0]      inst_q, inst_d;
    logic [INST_ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
    logic                       valid_q, valid_d;

    logic                       accept;
    logic                       skid_load;
    logic                       skid_drain;
    logic                       skid_valid;
    logic [INST_WIDTH-1:0]      skid_inst;
    logic [INST_ADDR_WIDTH-1:0] skid_addr;
    logic [INST_ADDR_WIDTH-1:0] jump_target;

    assign jump_target = word_align(jump_addr_i);

    // A response is kept only when it answers a live grant and no redirect is in progress.
    assign accept    = (state_q == IF_WAIT) && imem_rvalid_i && !drop_q && !jump_en_i;
    assign skid_load = accept && hold_i && valid_q;

    // Next state, PC and drop tracking; redirect overrides the normal flow.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        drop_d      = drop_q;
        case (state_q)
            IF_IDLE: state_d = IF_REQ;
            IF_REQ: begin
                if (imem_gnt_i) begin
                    state_d     = IF_WAIT;
                    pc_d        = pc_q + INST_ADDR_WIDTH'(4);
                    pend_addr_d = pc_q;
                end
            end
            IF_WAIT: begin
                if (imem_rvalid_i) begin
                    drop_d  = 1'b0;
                    state_d = skid_load ? IF_DONE : IF_REQ;
                end
            end
            IF_DONE: begin
                if (!skid_valid) begin
                    state_d = IF_REQ;
                end
            end
            default: state_d = IF_IDLE;
        endcase
        if (jump_en_i) begin
            pc_d = jump_target;
            case (state_q)
                // a grant in this same cycle leaves a response in flight
                IF_REQ: drop_d = imem_gnt_i;
                IF_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_d = IF_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                default: state_d = IF_REQ;
            endcase
        end
    end

    // Output register: load, hold, refill from skid, or fall back to NOP.
    always_comb begin
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        valid_d     = valid_q;
        skid_drain  = 1'b0;
        if (jump_en_i) begin
            inst_d  = INST_NOP;
            valid_d = 1'b0;
        end else if (accept && (!hold_i || !valid_q)) begin
            inst_d      = imem_rdata_i;
            inst_addr_d = pend_addr_q;
            valid_d     = 1'b1;
        end else if (!hold_i) begin
            if (skid_valid) begin
                inst_d      = skid_inst;
                inst_addr_d = skid_addr;
                valid_d     = 1'b1;
                skid_drain  = 1'b1;
            end else begin
                inst_d  = INST_NOP;
                valid_d = 1'b0;
            end
        end
    end

    // State, PC and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_ADDR;
            pend_addr_q <= RESET_ADDR;
            drop_q      <= 1'b0;
            inst_q      <= INST_NOP;
            inst_addr_q <= RESET_ADDR;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            drop_q      <= drop_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
            valid_q     <= valid_d;
        end
    end

    inst_fetch_skid u_if_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (jump_en_i),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .inst_i  (imem_rdata_i),
        .addr_i  (pend_addr_q),
        .valid_o (skid_valid),
        .inst_o  (skid_inst),
        .addr_o  (skid_addr)
    );

    assign imem_req_o   = (state_q == IF_REQ);
    assign imem_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign inst_valid_o = valid_q;

endmodule
